// File: rtl/tap_pkg.sv
// Shared types and constants for the LFSR tap-pattern search.
// Holds the search FSM state encoding, the tap table and a bounded table lookup.
// Contains no logic of its own.
package tap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_TAPS = 9;

  // Highest valid candidate index, kept as a 4-bit value so that
  // comparisons against the 4-bit candidate counter have matching widths.
  localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

  // Feedback tap masks. Bit i set means state bit i feeds the XOR.
  localparam logic [6:0] TAP_TABLE [NUM_TAPS] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Table read that returns zero for indices past the end of the table.
  // The candidate counter never leaves 0..8, so the zero case is unreachable.
  function automatic logic [6:0] tap_at(input logic [3:0] idx);
    logic [6:0] tap;
    tap = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (idx == 4'(i)) tap = TAP_TABLE[i];
    end
    return tap;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational advance of a 7-bit Fibonacci-style LFSR.
// Latency: purely combinational, zero cycles. No flow control.
// Ports: state = current LFSR state, tap = feedback mask, next = advanced state.
module lfsr_step (
  input  logic [6:0] state,
  input  logic [6:0] tap,
  output logic [6:0] next
);

  // Shift left by one and insert the parity of the tapped bits as the new LSB.
  assign next = {state[5:0], ^(state & tap)};

endmodule

// File: rtl/tap_finder.sv
// Finds the lowest tap-table entry that carries seed to target in STEPS LFSR advances.
// Latency: (STEPS+2)*(k+1)+1 cycles from accepted start to done for a match at index k,
//   (STEPS+2)*9+1 when nothing matches. No backpressure: start is ignored while busy.
// Ports: clk, reset (sync, active-high), start/seed/target request inputs;
//   busy (not idle), done (one-cycle pulse), found/index (result, held until next start).
module tap_finder
  import tap_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] seed,
  input  logic [6:0] target,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [3:0] index
);

  // Step counter runs 0..STEPS-1; the last value marks the final advance.
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  state_t     state_q;
  state_t     state_d;

  logic [6:0] seed_q;
  logic [6:0] target_q;
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_next;
  logic [3:0] cand_q;
  logic [3:0] step_q;
  logic       found_q;
  logic [3:0] index_q;

  logic       last_step;
  logic       match;
  logic       last_cand;

  lfsr_step u_lfsr_step (
    .state (lfsr_q),
    .tap   (tap_at(cand_q)),
    .next  (lfsr_next)
  );

  assign last_step = (step_q == LAST_STEP);
  assign match     = (lfsr_q == target_q);
  assign last_cand = (cand_q == LAST_TAP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = STEP;
      STEP:  if (last_step) state_d = CHECK;
      CHECK: begin
        if (match || last_cand) state_d = DONE;
        else                    state_d = LOAD;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; result registers drive found/index directly.
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    found = found_q;
    index = index_q;
  end

  // Datapath: request capture, LFSR, candidate and step counters, result.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q   <= '0;
      target_q <= '0;
      lfsr_q   <= '0;
      cand_q   <= '0;
      step_q   <= '0;
      found_q  <= 1'b0;
      index_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            seed_q   <= seed;
            target_q <= target;
            cand_q   <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
          end
        end
        LOAD: begin
          lfsr_q <= seed_q;
          step_q <= '0;
        end
        STEP: begin
          lfsr_q <= lfsr_next;
          step_q <= step_q + 4'd1;
        end
        CHECK: begin
          // Match is tested first so the lowest matching index wins and
          // the search stops there.
          if (match) begin
            found_q <= 1'b1;
            index_q <= cand_q;
          end else if (last_cand) begin
            found_q <= 1'b0;
          end else begin
            cand_q <= cand_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
